gray_code: RTL and testbench
============================

// Module: gray_code
// PURPOSE
// - Registered binary<->Gray code converter for counter/pointer encoding (e.g. CDC pointers).
// - Default build is a 4-bit binary-to-Gray encoder. A mode input selects Gray-to-binary
//   decode through the same pipeline. One output register stage, one cycle of latency.
// PARAMETERS
// - WIDTH      4   data width in bits; legal range >= 1
// PORTS
// - clk        in   1      clock; all state updates on its rising edge
// - rst        in   1      reset, synchronous, active-high
// - in         in   WIDTH  input code word: binary when mode=0, Gray when mode=1
// - in_valid   in   1      qualifies in/mode for the current cycle
// - mode       in   1      0 = binary->Gray encode; 1 = Gray->binary decode
// - gray       out  WIDTH  converted word (Gray if encoding, binary if decoding), registered
// - out_valid  out  1      gray holds a result produced from a valid input
// BEHAVIOUR
// - Interface: one clock; reset is synchronous and active-high.
// - Reset: while rst=1 at a clk edge, gray <= 0 and out_valid <= 0. Reset has priority
//   over in_valid. In-flight data is discarded. No output toggles until the next valid
//   input after rst is released.
// - Encode (mode=0): gray_n[i] = in[i] ^ in[i+1] for i < WIDTH-1; gray_n[WIDTH-1] = in[WIDTH-1].
//   Equivalently gray_n = in ^ (in >> 1).
// - Decode (mode=1): bin[WIDTH-1] = in[WIDTH-1]; bin[i] = bin[i+1] ^ in[i], computed MSB down
//   to LSB (prefix XOR). Pure combinational chain ahead of the register.
// - Latency: in_valid=1 at edge k -> gray=f(in,mode) and out_valid=1 after edge k, stable
//   through cycle k+1.
// - Hold: in_valid=0 at an edge -> gray keeps its previous value and out_valid <= 0.
// - Back-to-back: a valid input every cycle gives a result every cycle. No stalls, no
//   backpressure.
// - Width rules: no carries or arithmetic, outputs exactly WIDTH bits. WIDTH=1 gives
//   gray = in in both modes.
// - Wrap-around: encoding all-ones gives 1 followed by zeros. For any binary b, the encoded
//   values of b and b+1 mod 2^WIDTH differ in exactly one bit, including the
//   2^WIDTH-1 -> 0 wrap.
// - Round trip: decode(encode(x)) = x for all x.
// - X-safety: the output register loads only when in_valid=1. Unknown data on idle
//   cycles must not propagate.
// TESTING
// - Reset: hold rst=1 for 3 cycles with in_valid=1, in=4'hF -> gray=0, out_valid=0
//   throughout.
// - Encode sweep, mode=0: in=0..15, one value every cycle ->
//   gray=0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8, each one cycle later, with out_valid=1.
// - Single-bit step: across the encode sweep, consecutive outputs differ in exactly one
//   bit, including the 8 (in=15) -> 0 (in=0) wrap.
// - Decode, mode=1: in=4'hC -> gray=4'h8; in=4'h8 -> 4'hF; in=4'hB -> 4'hD.
//   Round-trip all 16 values.
// - Hold/idle: valid in=4'h5 (gray=7), then in_valid=0 with in=4'hA -> gray stays 7,
//   out_valid drops to 0.
// - Mid-stream reset: rst=1 during a valid sweep -> next cycle gray=0, out_valid=0. The sweep
//   resumes correctly one cycle after rst deasserts.

Source files
------------

// File: rtl/gray_code.sv
// ---------------------------------------------------------------------------
// gray_code
//
// Registered binary <-> Gray code converter, typically used to encode and
// decode counters or FIFO pointers that cross clock domains. Encode and
// decode share a single output register, so there is one cycle of latency
// in either mode.
//
// Parameters
//   WIDTH      data width in bits (>= 1)
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous, active-high reset; clears gray and out_valid
//   in         input code word (binary when mode=0, Gray when mode=1)
//   in_valid   qualifies in/mode for the current cycle
//   mode       0 = binary->Gray encode, 1 = Gray->binary decode
//   gray       registered converted word
//   out_valid  gray holds a result produced from a valid input
// ---------------------------------------------------------------------------
module gray_code #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  input  logic             mode,
  output logic [WIDTH-1:0] gray,
  output logic             out_valid
);

  logic [WIDTH-1:0] enc_word;
  logic [WIDTH-1:0] dec_word;
  logic [WIDTH-1:0] next_word;

  // Binary to Gray: each bit is the XOR of itself and its upper neighbour;
  // the MSB passes straight through.
  always_comb begin
    enc_word = in ^ (in >> 1);
  end

  // Gray to binary is a running XOR from the MSB down: every binary bit is
  // the parity of all Gray bits at or above it.
  always_comb begin
    logic acc;
    acc      = 1'b0;
    dec_word = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      acc         = acc ^ in[i];
      dec_word[i] = acc;
    end
  end

  always_comb begin
    next_word = mode ? dec_word : enc_word;
  end

  // The data register only loads on a valid input, so garbage on idle
  // cycles never reaches gray; out_valid is a one-cycle pulse per input.
  always_ff @(posedge clk) begin
    if (rst) begin
      gray      <= '0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      gray      <= next_word;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gray_code.sv
// ---------------------------------------------------------------------------
// tb_gray_code
//
// Self-checking bench for gray_code. The driver issues one input per cycle
// and pushes the expected registered output onto a scoreboard queue; a
// monitor pops one entry per clock and compares it with the DUT. The
// reference Gray sequence is built with the reflect-and-prefix construction
// and decoding is done by searching that sequence.
// ---------------------------------------------------------------------------
module tb_gray_code;

  localparam int W = 4;
  localparam int N = 1 << W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         mode = 1'b0;
  logic [W-1:0] in_word = '0;
  logic [W-1:0] gray;
  logic         out_valid;

  typedef struct {
    logic         v;
    logic [W-1:0] g;
    bit           step;
  } exp_t;

  exp_t         sb[$];
  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] gray_table [N];
  logic [W-1:0] model_gray = '0;
  bit           step_en    = 1'b0;
  bit           have_prev  = 1'b0;
  logic [W-1:0] prev_gray  = '0;

  always #5 clk = ~clk;

  gray_code #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in_word),
    .in_valid  (in_valid),
    .mode      (mode),
    .gray      (gray),
    .out_valid (out_valid)
  );

  // Reflected Gray sequence: the next 2^k entries are the first 2^k in
  // reverse order with bit k set.
  task automatic buildTable();
    gray_table[0] = '0;
    for (int k = 0; k < W; k++) begin
      int half;
      half = 1 << k;
      for (int i = 0; i < half; i++)
        gray_table[half + i] = gray_table[half - 1 - i] | W'(half);
    end
  endtask

  function automatic logic [W-1:0] refEncode(input logic [W-1:0] b);
    return gray_table[int'(b)];
  endfunction

  function automatic logic [W-1:0] refDecode(input logic [W-1:0] g);
    logic [W-1:0] r;
    r = '0;
    for (int j = 0; j < N; j++)
      if (gray_table[j] == g) r = W'(j);
    return r;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  // Drives one cycle of inputs and records what the output register must
  // hold after the following rising edge.
  task automatic applyStimulus(input logic r, input logic v, input logic m,
                               input logic [W-1:0] d);
    exp_t e;
    @(negedge clk);
    rst      = r;
    in_valid = v;
    mode     = m;
    in_word  = d;
    if (r) begin
      model_gray = '0;
      e.v = 1'b0;
    end else if (v) begin
      model_gray = m ? refDecode(d) : refEncode(d);
      e.v = 1'b1;
    end else begin
      e.v = 1'b0;
    end
    e.g    = model_gray;
    e.step = step_en;
    sb.push_back(e);
  endtask

  // Monitor: one scoreboard entry per clock, sampled after the edge settles.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checkOutput("out_valid", int'(out_valid), int'(e.v));
      checkOutput("gray", int'(gray), int'(e.g));
      if (e.step && out_valid) begin
        if (have_prev)
          checkOutput("single_bit_step", $countones(gray ^ prev_gray), 1);
        prev_gray = gray;
        have_prev = 1'b1;
      end
    end
  end

  initial begin
    buildTable();

    // Reset held with a valid all-ones input present.
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 4'hF);

    // Encode sweep including the wrap back to zero.
    step_en = 1'b1;
    for (int i = 0; i <= N; i++) applyStimulus(1'b0, 1'b1, 1'b0, W'(i % N));
    step_en = 1'b0;

    // Decode examples.
    applyStimulus(1'b0, 1'b1, 1'b1, 4'hC);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'h8);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'hB);

    // Round trip: decode every encoded value.
    for (int i = 0; i < N; i++) applyStimulus(1'b0, 1'b1, 1'b1, refEncode(W'(i)));

    // Hold / idle.
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h5);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'hA);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'h3);

    // Mid-stream reset then resume.
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b0, W'(i));
    applyStimulus(1'b1, 1'b1, 1'b0, 4'h8);
    for (int i = 9; i < N; i++) applyStimulus(1'b0, 1'b1, 1'b0, W'(i));

    // Randomized traffic.
    for (int i = 0; i < 300; i++)
      applyStimulus(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 1)), W'($urandom_range(0, N - 1)));

    // Idle out and drain the scoreboard with a bounded wait.
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      failures++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
